// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register
//
// Fetches one instruction per cycle from a ready/valid-style instruction
// memory and presents it, with its PC and PC+4, to the decode stage through
// a registered IF/ID interface. Handles hazard stalls (via a one-entry hold
// buffer), IF/ID flushes, and control-flow redirects from EX, including a
// redirect that arrives while a memory request is still outstanding.
//
// Parameters
//   INST_WIDTH       instruction width
//   INST_ADDR_WIDTH  PC / address width
//   RESET_PC         first fetch address after reset
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   stall_IF             hold PC and IF/ID
//   flush_IF_ID          load a bubble into IF/ID
//   pc_redirect_EX       redirect request from EX
//   pc_target_EX         redirect target
//   imem_req, imem_addr  instruction memory request / address
//   imem_ready, imem_rdata  memory response handshake / data
//   INST_IF_ID_o, PC_IF_ID_o, PC_plus_4_IF_ID_o, valid_IF_ID_o  IF/ID outputs
//   fetch_cnt            count of valid IF/ID loads (only with IF_FETCH_CNT_EN)
//
// Optional feature macro: IF_FETCH_CNT_EN
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall_IF,
  input  logic                       flush_IF_ID,
  input  logic                       pc_redirect_EX,
  input  logic [INST_ADDR_WIDTH-1:0] pc_target_EX,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ready,
  input  logic [INST_WIDTH-1:0]      imem_rdata,
  output logic [INST_WIDTH-1:0]      INST_IF_ID_o,
  output logic [INST_ADDR_WIDTH-1:0] PC_IF_ID_o,
  output logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF_ID_o,
  output logic                       valid_IF_ID_o
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0]                fetch_cnt
`endif
);

  localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  // What happens to the IF/ID register on the next edge.
  typedef enum logic [1:0] {IFID_KEEP, IFID_BUBBLE, IFID_LOAD_MEM, IFID_LOAD_BUF} ifid_op_t;

  state_t                     state, state_nxt;
  ifid_op_t                   ifid_op;
  logic [INST_ADDR_WIDTH-1:0] pc, pc_nxt, pc_plus_4;
  logic [INST_ADDR_WIDTH-1:0] drop_target, drop_target_nxt;
  logic [INST_WIDTH-1:0]      hold_buf, hold_buf_nxt;

  // Address stays on pc for the whole request, including in DROP, so the
  // memory sees a stable address until it answers.
  assign imem_addr = pc;
  assign pc_plus_4 = pc + INST_ADDR_WIDTH'(4);

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    drop_target_nxt = drop_target;
    hold_buf_nxt    = hold_buf;
    ifid_op         = IFID_KEEP;
    imem_req        = 1'b0;

    case (state)
      IDLE: begin
        ifid_op   = IFID_BUBBLE;
        state_nxt = FETCH;
        if (pc_redirect_EX) pc_nxt = pc_target_EX;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (pc_redirect_EX) begin
            ifid_op = IFID_BUBBLE;
            pc_nxt  = pc_target_EX;
          end else if (stall_IF) begin
            // Memory answered but ID cannot accept: park the word.
            hold_buf_nxt = imem_rdata;
            state_nxt    = HOLD;
          end else begin
            ifid_op = IFID_LOAD_MEM;
            pc_nxt  = pc_plus_4;
          end
        end else begin
          ifid_op = IFID_BUBBLE;
          if (pc_redirect_EX) begin
            // Request already in flight; wait it out before retargeting.
            drop_target_nxt = pc_target_EX;
            state_nxt       = DROP;
          end
        end
      end

      HOLD: begin
        if (pc_redirect_EX) begin
          ifid_op   = IFID_BUBBLE;
          pc_nxt    = pc_target_EX;
          state_nxt = FETCH;
        end else if (!stall_IF) begin
          ifid_op   = IFID_LOAD_BUF;
          pc_nxt    = pc_plus_4;
          state_nxt = FETCH;
        end
      end

      DROP: begin
        imem_req = 1'b1;
        ifid_op  = IFID_BUBBLE;
        if (pc_redirect_EX) drop_target_nxt = pc_target_EX;
        if (imem_ready) begin
          // A redirect arriving in the same cycle is the newest target.
          pc_nxt    = pc_redirect_EX ? pc_target_EX : drop_target;
          state_nxt = FETCH;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Flush beats stall beats whatever the FSM wanted.
    if (flush_IF_ID)   ifid_op = IFID_BUBBLE;
    else if (stall_IF) ifid_op = IFID_KEEP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      pc                <= RESET_PC;
      drop_target       <= '0;
      hold_buf          <= '0;
      INST_IF_ID_o      <= NOP_INST;
      PC_IF_ID_o        <= '0;
      PC_plus_4_IF_ID_o <= '0;
      valid_IF_ID_o     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drop_target <= drop_target_nxt;
      hold_buf    <= hold_buf_nxt;
      case (ifid_op)
        IFID_BUBBLE: begin
          INST_IF_ID_o      <= NOP_INST;
          PC_IF_ID_o        <= '0;
          PC_plus_4_IF_ID_o <= '0;
          valid_IF_ID_o     <= 1'b0;
        end
        IFID_LOAD_MEM: begin
          INST_IF_ID_o      <= imem_rdata;
          PC_IF_ID_o        <= pc;
          PC_plus_4_IF_ID_o <= pc_plus_4;
          valid_IF_ID_o     <= 1'b1;
        end
        IFID_LOAD_BUF: begin
          INST_IF_ID_o      <= hold_buf;
          PC_IF_ID_o        <= pc;
          PC_plus_4_IF_ID_o <= pc_plus_4;
          valid_IF_ID_o     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (ifid_op == IFID_LOAD_MEM || ifid_op == IFID_LOAD_BUF) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction width.
REQ-002 SHALL have parameter INST_ADDR_WIDTH, default 32, PC/address width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk input 1 rising-edge clock; all state updates on its rising edge.
REQ-005 rst_n input 1 synchronous active-low reset, sampled on rising clk.
REQ-006 stall_IF input 1 hazard hold; IF/ID and PC keep their values.
REQ-007 flush_IF_ID input 1 IF/ID loads a bubble next edge.
REQ-008 pc_redirect_EX input 1 taken branch/jump resolved downstream.
REQ-009 pc_target_EX input INST_ADDR_WIDTH redirect address.
REQ-010 imem_req output 1 instruction memory request.
REQ-011 imem_addr output INST_ADDR_WIDTH request address.
REQ-012 imem_ready input 1 memory returns imem_rdata this cycle.
REQ-013 imem_rdata input INST_WIDTH fetched instruction.
REQ-014 INST_IF_ID_o output INST_WIDTH registered instruction to ID.
REQ-015 PC_IF_ID_o output INST_ADDR_WIDTH registered PC of that instruction.
REQ-016 PC_plus_4_IF_ID_o output INST_ADDR_WIDTH registered PC+4.
REQ-017 valid_IF_ID_o output 1 IF/ID holds a real instruction.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HOLD, DROP.
REQ-019 IDLE: imem_req=0; unconditionally -> FETCH next cycle.
REQ-020 FETCH: imem_req=1, imem_addr=pc; imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-021 FETCH, imem_ready=1, no redirect, stall_IF=0: IF/ID <= {imem_rdata, pc, pc+4}, valid=1; pc <= pc+4; stay FETCH (back-to-back, one instruction per cycle with 0-wait memory).
REQ-022 FETCH, imem_ready=1, stall_IF=1: imem_rdata captured in hold buffer; IF/ID unchanged; -> HOLD.
REQ-023 FETCH, imem_ready=0, stall_IF=0: IF/ID <= bubble.
REQ-024 HOLD: imem_req=0; when stall_IF=0, IF/ID <= {buffer, pc, pc+4}, valid=1, pc <= pc+4, -> FETCH.
REQ-025 Redirect in FETCH with imem_ready=1 or in HOLD: returned/buffered instruction discarded, pc <= pc_target_EX, -> FETCH.
REQ-026 Redirect in FETCH with imem_ready=0: target latched, -> DROP; DROP keeps imem_req=1 at old address until imem_ready=1, discards data, pc <= latched target, -> FETCH.
REQ-027 A later redirect during DROP SHALL overwrite the latched target.
REQ-028 Bubble = INST 32'h0000_0013 (NOP), PC 0, PC+4 0, valid 0.
REQ-029 Priority for IF/ID register: reset > flush_IF_ID > stall_IF > load/bubble; flush with stall SHALL still bubble.
REQ-030 Priority for pc: reset > redirect > stall_IF > increment.
REQ-031 pc+4 SHALL wrap modulo 2^INST_ADDR_WIDTH (32'hFFFF_FFFC -> 0).
REQ-032 Outputs to ID SHALL be registered only; no combinational path from imem_rdata.

Reset
REQ-033 On rst_n=0 at clk edge: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, IF/ID = bubble, hold buffer=0, DROP target=0.
REQ-034 Reset mid-request SHALL abandon the outstanding fetch; a late imem_ready after reset is ignored in IDLE.

Configuration
REQ-035 Macro IF_FETCH_CNT_EN defined: SHALL add output fetch_cnt [31:0], reset 0, +1 each cycle valid_IF_ID_o is loaded 1, wraps at 2^32.
REQ-036 Macro undefined: port fetch_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-037 Reset, ready tied 1, rdata=addr-derived: IDLE one cycle, then IF/ID PCs 0,4,8 on consecutive cycles, valid=1.
REQ-038 stall_IF=1 for 3 cycles while ready=1 at PC 8: IF/ID holds PC 4; after release PC 8 appears once, no instruction lost or duplicated.
REQ-039 ready=0 for 2 cycles at PC 0x10, redirect to 0x100 in first: imem_addr stays 0x10 until ready, data discarded, next imem_addr 0x100.
REQ-040 flush_IF_ID=1 with stall_IF=1: next IF/ID = 32'h0000_0013, valid 0.
REQ-041 RESET_PC=32'hFFFF_FFFC: second fetch address 0; with IF_FETCH_CNT_EN, fetch_cnt=2 after two valid loads, 0 after reset.
